// File: rtl/wash_pkg.sv
// wash_pkg
//   State encoding shared by the washing-machine controller and the
//   appliance-side phase sequencer, plus a helper that says which
//   states are timed phases.
package wash_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_FILL  = 3'b001,
      ST_WASH  = 3'b010,
      ST_RINSE = 3'b011,
      ST_SPIN  = 3'b100,
      ST_DRAIN = 3'b101,
      ST_END   = 3'b110,
      ST_ERROR = 3'b111
   } wash_state_e;

   // Wash, rinse, spin and drain are the only phases with a duration.
   function automatic logic is_timed(input logic [2:0] s);
      return (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Free-running divider producing the time-base tick for the phase timer
//   and the level model.
//   Ports:
//     clk  in  clock
//     rst  in  asynchronous, active-low reset
//     tick out 1 during the cycle in which the count equals TICK_DIV-1
module tick_prescaler #(
   parameter int TICK_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (count_q == LAST) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + 1'b1;
      end
   end

   assign tick = (count_q == LAST);

endmodule

// File: rtl/wash_phase_sequencer.sv
// wash_phase_sequencer
//   Plant model for the washing-machine controller: tracks drum water level
//   from the valve commands and times the wash/rinse/spin/drain phases.
//   Ports:
//     clk, rst (async active-low)
//     state          controller state code (wash_pkg encoding)
//     motor_on       drum motor command (run condition of wash/rinse/spin)
//     water_valve    inlet valve command
//     drain_valve    drain valve command (run condition of drain)
//     water_level    1 when level is full
//     cycle_complete one-clk pulse when the current timed phase finishes
//     level          water level count
//     phase_timer    elapsed ticks in the current phase
//     valve_conflict sticky flag: inlet and drain seen together on a tick
module wash_phase_sequencer import wash_pkg::*; #(
   parameter int TICK_DIV    = 16,
   parameter int LEVEL_W     = 4,
   parameter int LEVEL_MAX   = 10,
   parameter int TIMER_W     = 8,
   parameter int WASH_TICKS  = 20,
   parameter int RINSE_TICKS = 12,
   parameter int SPIN_TICKS  = 8,
   parameter int DRAIN_TICKS = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         state,
   input  logic               motor_on,
   input  logic               water_valve,
   input  logic               drain_valve,
   output logic               water_level,
   output logic               cycle_complete,
   output logic [LEVEL_W-1:0] level,
   output logic [TIMER_W-1:0] phase_timer,
   output logic               valve_conflict
);

   localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(LEVEL_MAX);
   localparam logic [TIMER_W-1:0] WASH_DUR   = TIMER_W'(WASH_TICKS);
   localparam logic [TIMER_W-1:0] RINSE_DUR  = TIMER_W'(RINSE_TICKS);
   localparam logic [TIMER_W-1:0] SPIN_DUR   = TIMER_W'(SPIN_TICKS);
   localparam logic [TIMER_W-1:0] DRAIN_DUR  = TIMER_W'(DRAIN_TICKS);

   logic               tick;
   logic [2:0]         state_q;
   logic [TIMER_W-1:0] timer_q;
   logic               done_q;
   logic               pulse_q;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               conflict_q, conflict_d;

   logic               phase_change;
   logic [TIMER_W-1:0] phase_dur;
   logic               phase_run;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign phase_change = (state != state_q);

   // Duration and run condition of the phase currently commanded.
   always_comb begin
      phase_dur = '0;
      phase_run = 1'b0;
      case (state)
         ST_WASH:  begin phase_dur = WASH_DUR;  phase_run = motor_on;    end
         ST_RINSE: begin phase_dur = RINSE_DUR; phase_run = motor_on;    end
         ST_SPIN:  begin phase_dur = SPIN_DUR;  phase_run = motor_on;    end
         ST_DRAIN: begin phase_dur = DRAIN_DUR; phase_run = drain_valve; end
         default:  ;
      endcase
   end

   // Phase timer: a state change always restarts it, even on a tick edge.
   // done_q blocks further counting so each phase entry pulses at most once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= '0;
         timer_q <= '0;
         done_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state;
         pulse_q <= 1'b0;
         if (phase_change) begin
            timer_q <= '0;
            done_q  <= 1'b0;
         end else if (is_timed(state) && phase_run && tick && !done_q) begin
            if (timer_q == phase_dur - 1'b1) begin
               timer_q <= phase_dur;
               done_q  <= 1'b1;
               pulse_q <= 1'b1;
            end else begin
               timer_q <= timer_q + 1'b1;
            end
         end
      end
   end

   // Level moves one step per tick; opposing valves hold it and latch a conflict.
   always_comb begin
      level_d    = level_q;
      conflict_d = conflict_q;
      if (tick) begin
         if (water_valve && drain_valve) begin
            conflict_d = 1'b1;
         end else if (water_valve && (level_q != LEVEL_FULL)) begin
            level_d = level_q + 1'b1;
         end else if (drain_valve && (level_q != '0)) begin
            level_d = level_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_q    <= '0;
         conflict_q <= 1'b0;
      end else begin
         level_q    <= level_d;
         conflict_q <= conflict_d;
      end
   end

   assign water_level    = (level_q == LEVEL_FULL);
   assign cycle_complete = pulse_q;
   assign level          = level_q;
   assign phase_timer    = timer_q;
   assign valve_conflict = conflict_q;

endmodule

// File: tb/tb_wash_phase_sequencer.sv
module tb_wash_phase_sequencer;
   import wash_pkg::*;

   localparam int TD = 4;
   localparam int LM = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] state = 3'b000;
   logic       motor_on = 1'b0;
   logic       water_valve = 1'b0;
   logic       drain_valve = 1'b0;
   logic       water_level, cycle_complete, valve_conflict;
   logic [3:0] level;
   logic [7:0] phase_timer;

   int checks = 0;
   int errors = 0;

   // Reference model: cycles since reset release, elapsed ticks per phase entry.
   int         m_cyc, m_elapsed, m_level;
   logic [2:0] m_prev;
   bit         m_done, m_pulse, m_conflict;

   always #5 clk = ~clk;

   wash_phase_sequencer #(
      .TICK_DIV(TD), .LEVEL_W(4), .LEVEL_MAX(LM), .TIMER_W(8),
      .WASH_TICKS(5), .RINSE_TICKS(12), .SPIN_TICKS(8), .DRAIN_TICKS(6)
   ) dut (
      .clk(clk), .rst(rst), .state(state), .motor_on(motor_on),
      .water_valve(water_valve), .drain_valve(drain_valve),
      .water_level(water_level), .cycle_complete(cycle_complete),
      .level(level), .phase_timer(phase_timer), .valve_conflict(valve_conflict)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int dur_of(input logic [2:0] s);
      case (s)
         3'b010:  return 5;
         3'b011:  return 12;
         3'b100:  return 8;
         3'b101:  return 6;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_elapsed = 0; m_level = 0; m_prev = 3'b000;
      m_done = 0; m_pulse = 0; m_conflict = 0;
   endtask

   // Advance the model by one clock edge using the inputs present before it.
   task automatic model_edge();
      bit tick_now;
      bit runs;
      tick_now = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      m_pulse = 0;
      runs = (state == 3'b101) ? drain_valve : motor_on;
      if (state != m_prev) begin
         m_elapsed = 0;
         m_done = 0;
      end else if (dur_of(state) > 0 && runs && tick_now && !m_done) begin
         m_elapsed++;
         if (m_elapsed == dur_of(state)) begin
            m_done = 1;
            m_pulse = 1;
         end
      end
      m_prev = state;
      if (tick_now) begin
         if (water_valve && drain_valve) m_conflict = 1;
         else if (water_valve)          m_level = (m_level < LM) ? m_level + 1 : LM;
         else if (drain_valve)          m_level = (m_level > 0) ? m_level - 1 : 0;
      end
   endtask

   task automatic check_all();
      chk("phase_timer", phase_timer, m_elapsed);
      chk("cycle_complete", cycle_complete, m_pulse);
      chk("level", level, m_level);
      chk("water_level", water_level, (m_level == LM));
      chk("valve_conflict", valve_conflict, m_conflict);
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_timer"}, phase_timer, 0);
      chk({tag, "_pulse"}, cycle_complete, 0);
      chk({tag, "_level"}, level, 0);
      chk({tag, "_wlevel"}, water_level, 0);
      chk({tag, "_conflict"}, valve_conflict, 0);
   endtask

   // Reset asserted mid-cycle: outputs must clear without waiting for a clock.
   task automatic do_reset(input string tag);
      rst = 1'b0;
      #1;
      check_zero({tag, "_async"});
      repeat (2) @(posedge clk);
      #1;
      check_zero({tag, "_held"});
      rst = 1'b1;
      model_reset();
   endtask

   task automatic wait_timer(input int val, input int limit);
      bit hit = 0;
      for (int i = 0; i < limit && !hit; i++) begin
         cycle();
         if (phase_timer == 8'(val)) hit = 1;
      end
      chk("wait_timer_bound", hit, 1);
   endtask

   task automatic wait_level(input int val, input int limit);
      bit hit = 0;
      for (int i = 0; i < limit && !hit; i++) begin
         cycle();
         if (level == 4'(val)) hit = 1;
      end
      chk("wait_level_bound", hit, 1);
   endtask

   task automatic count_pulses(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         cycle();
         if (cycle_complete === 1'b1) pulses++;
      end
   endtask

   initial begin
      int np;
      // 1: reset with actuators active
      rst = 1'b0; state = 3'b010; motor_on = 1; water_valve = 1; drain_valve = 1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_active");
      state = 3'b000; motor_on = 0; water_valve = 0; drain_valve = 0;
      rst = 1'b1;
      model_reset();

      // 2: fill; first tick lands on the 4th edge after release
      state = 3'b001; water_valve = 1;
      repeat (3) cycle();
      chk("pre_first_tick", level, 0);
      cycle();
      chk("first_tick", level, 1);
      repeat (40) cycle();
      chk("fill_saturate", level, LM);
      chk("fill_full", water_level, 1);
      water_valve = 0;

      // 3: wash runs to a single pulse
      state = 3'b010; motor_on = 1;
      count_pulses(60, np);
      chk("wash_pulses", np, 1);
      chk("wash_timer_final", phase_timer, 5);

      // 4: pause at timer 2 for three ticks
      state = 3'b000; cycle();
      state = 3'b010;
      wait_timer(2, 20);
      motor_on = 0;
      repeat (12) cycle();
      chk("pause_hold", phase_timer, 2);
      motor_on = 1;
      count_pulses(20, np);
      chk("pause_pulses", np, 1);

      // 5: abort to ERROR at timer 3, then full re-run
      state = 3'b000; cycle();
      state = 3'b010;
      wait_timer(3, 24);
      state = 3'b111;
      count_pulses(8, np);
      chk("abort_no_pulse", np, 0);
      chk("abort_timer", phase_timer, 0);
      state = 3'b010;
      count_pulses(30, np);
      chk("rerun_pulses", np, 1);

      // 6: valve conflict at level 4
      state = 3'b101; motor_on = 0; drain_valve = 1;
      wait_level(4, 40);
      water_valve = 1;
      repeat (12) cycle();
      chk("conflict_level", level, 4);
      chk("conflict_set", valve_conflict, 1);
      water_valve = 0; drain_valve = 0;
      repeat (8) cycle();
      chk("conflict_sticky", valve_conflict, 1);
      do_reset("conflict_rst");

      // Randomized phases and actuators, with a reset mid-run
      for (int i = 0; i < 800; i++) begin
         if (i == 400) do_reset("mid_run");
         if ($urandom_range(15) == 0) state = 3'($urandom_range(7));
         if ($urandom_range(7) == 0) motor_on = ($urandom_range(3) != 0);
         if ($urandom_range(7) == 0) water_valve = ($urandom_range(1) == 1);
         if ($urandom_range(7) == 0) drain_valve = ($urandom_range(2) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
